// File: rtl/c432_key_loader.sv
// Serial loader for the camouflaged c432 select key (s_0..s_11), committed atomically.
// Optional trailing even-parity bit enabled by defining CAM_KEY_PARITY_EN.
module c432_key_loader #(
    parameter int unsigned NUM_CAM      = 6,
    parameter int unsigned BITS_PER_CAM = 2,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                key_bit,
    input  logic                                key_valid,
    output logic                                key_ready,
    output logic [NUM_CAM*BITS_PER_CAM-1:0]     key_out,
    output logic                                key_locked,
    output logic                                busy,
    output logic                                load_err
);

    localparam int unsigned KEY_W  = NUM_CAM * BITS_PER_CAM;
    localparam int unsigned CNT_W  = $clog2(KEY_W + 1);
    localparam int unsigned IDLE_W = 8;

`ifdef CAM_KEY_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_PAR    = 3'd2,
        ST_COMMIT = 3'd3,
        ST_ERR    = 3'd4
    } state_t;
    localparam state_t ST_AFTER_SHIFT = ST_PAR;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_COMMIT = 3'd3,
        ST_ERR    = 3'd4
    } state_t;
    localparam state_t ST_AFTER_SHIFT = ST_COMMIT;
`endif

    state_t             state_q;
    logic [KEY_W-1:0]   shadow_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [IDLE_W-1:0]  idle_cnt_q;
    logic [KEY_W-1:0]   key_out_q;
    logic               key_locked_q;
    logic               busy_q;
    logic               load_err_q;

    logic               last_bit_c;
    logic               timeout_c;

    // This idle cycle is the TIMEOUT-th one since the last accept.
    assign timeout_c  = (idle_cnt_q == IDLE_W'(TIMEOUT - 1));
    assign last_bit_c = (bit_cnt_q == CNT_W'(KEY_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shadow_q     <= '0;
            bit_cnt_q    <= '0;
            idle_cnt_q   <= '0;
            key_out_q    <= '0;
            key_locked_q <= 1'b0;
            busy_q       <= 1'b0;
            load_err_q   <= 1'b0;
        end else if (start) begin
            // Restart from any state; a bit offered this cycle is dropped.
            state_q    <= ST_SHIFT;
            shadow_q   <= '0;
            bit_cnt_q  <= '0;
            idle_cnt_q <= '0;
            busy_q     <= 1'b1;
            load_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (key_valid) begin
                        shadow_q   <= {key_bit, shadow_q[KEY_W-1:1]};
                        idle_cnt_q <= '0;
                        if (last_bit_c) begin
                            bit_cnt_q <= '0;
                            state_q   <= ST_AFTER_SHIFT;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end else if (timeout_c) begin
                        state_q <= ST_ERR;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
                    end
                end
`ifdef CAM_KEY_PARITY_EN
                ST_PAR: begin
                    // Even parity over key bits plus the trailing parity bit.
                    if (key_valid) begin
                        idle_cnt_q <= '0;
                        if ((^shadow_q) ^ key_bit) begin
                            state_q <= ST_ERR;
                        end else begin
                            state_q <= ST_COMMIT;
                        end
                    end else if (timeout_c) begin
                        state_q <= ST_ERR;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
                    end
                end
`endif
                ST_COMMIT: begin
                    key_out_q    <= shadow_q;
                    key_locked_q <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                ST_ERR: begin
                    load_err_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CAM_KEY_PARITY_EN
    assign key_ready = (state_q == ST_SHIFT) || (state_q == ST_PAR);
`else
    assign key_ready = (state_q == ST_SHIFT);
`endif

    assign key_out    = key_out_q;
    assign key_locked = key_locked_q;
    assign busy       = busy_q;
    assign load_err   = load_err_q;

endmodule
